// File: rtl/mac_pipe.sv
// Multi-lane signed multiply-accumulate engine with a shared, multi-cycle operand load port.
// A one-hot instruction stream is gated by structural and RAW hazard checks.
module mac_pipe #(
   parameter int DATA_W     = 8,
   parameter int ACC_W      = 20,
   parameter int LANES      = 4,
   parameter int MUL_STAGES = 2,
   parameter int LOAD_CYC   = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                inst,
   input  logic                      inst_valid,
   output logic                      inst_ready,
   input  logic [LANES*DATA_W-1:0]   data_in,
   input  logic [LANES*DATA_W-1:0]   coeff_in,
   output logic [LANES*ACC_W-1:0]    wr_data,
   output logic                      wr_valid,
   output logic                      err,
   output logic [15:0]               stall_cnt
);
   localparam int PW = 2 * DATA_W;
   localparam int CW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

   logic is_nop, is_ldd, is_ldc, is_ld, is_mac, is_wr, is_ill;
   logic accept, ld_busy, mac_busy, mac_go, wr_go, ld_commit, ld_tgt_coeff, acc_en;
   logic [CW-1:0]         ld_cnt_q, ld_cnt_d;
   logic                  ld_coeff_q, ld_coeff_d;
   logic [MUL_STAGES-1:0] pv_q, pv_d;
   logic                  err_q, err_d, wr_valid_q, wr_valid_d;
   logic [15:0]           stall_cnt_q, stall_cnt_d;

   assign is_nop = (inst == 8'h01);
   assign is_ldd = (inst == 8'h02);
   assign is_ldc = (inst == 8'h04);
   assign is_mac = (inst == 8'h18);
   assign is_wr  = (inst == 8'h20);
   assign is_ld  = is_ldd | is_ldc;
   assign is_ill = ~(is_nop | is_ld | is_mac | is_wr);

   assign ld_busy  = (ld_cnt_q != '0);
   assign mac_busy = |pv_q;
   assign accept   = inst_valid & inst_ready;
   assign mac_go   = accept & is_mac;
   assign wr_go    = accept & is_wr;
   assign acc_en   = pv_q[MUL_STAGES-1];

   // Loads and MACs both wait on the load port; WRITE waits for the MAC pipe to drain.
   always_comb begin
      inst_ready = 1'b0;
      if (rst_n) begin
         if (is_ld || is_mac) inst_ready = ~ld_busy;
         else if (is_wr)      inst_ready = ~mac_busy;
         else                 inst_ready = 1'b1;
      end
   end

   always_comb begin
      ld_cnt_d     = ld_cnt_q;
      ld_coeff_d   = ld_coeff_q;
      ld_commit    = 1'b0;
      ld_tgt_coeff = ld_coeff_q;
      if (LOAD_CYC == 1) begin
         ld_commit    = accept & is_ld;
         ld_tgt_coeff = is_ldc;
      end else begin
         if (ld_busy) begin
            ld_cnt_d  = ld_cnt_q - 1'b1;
            ld_commit = (ld_cnt_q == CW'(1));
         end
         if (accept && is_ld) begin
            ld_cnt_d   = CW'(LOAD_CYC - 1);
            ld_coeff_d = is_ldc;
         end
      end
      pv_d        = (pv_q << 1) | MUL_STAGES'(mac_go);
      err_d       = accept & is_ill;
      wr_valid_d  = wr_go;
      stall_cnt_d = stall_cnt_q;
      if (inst_valid && !inst_ready && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_cnt_q    <= '0;
         ld_coeff_q  <= 1'b0;
         pv_q        <= '0;
         err_q       <= 1'b0;
         wr_valid_q  <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         ld_cnt_q    <= ld_cnt_d;
         ld_coeff_q  <= ld_coeff_d;
         pv_q        <= pv_d;
         err_q       <= err_d;
         wr_valid_q  <= wr_valid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign err       = err_q;
   assign wr_valid  = wr_valid_q;
   assign stall_cnt = stall_cnt_q;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DATA_W-1:0] din, cin, src;
      logic signed [DATA_W-1:0] buf_q, buf_d, data_q, data_d, coeff_q, coeff_d;
      logic signed [PW-1:0]     prod;
      logic signed [PW-1:0]     pp_q [MUL_STAGES];
      logic signed [PW-1:0]     pp_d [MUL_STAGES];
      logic signed [ACC_W-1:0]  ext, acc_q, acc_d, wr_q, wr_d;

      assign din  = data_in[gi*DATA_W +: DATA_W];
      assign cin  = coeff_in[gi*DATA_W +: DATA_W];
      assign prod = data_q * coeff_q;
      assign ext  = pp_q[MUL_STAGES-1];

      always_comb begin
         buf_d = buf_q;
         if (accept && is_ld) buf_d = is_ldc ? cin : din;
         // A single-cycle load commits the operand sampled on the same edge.
         src     = (LOAD_CYC == 1) ? buf_d : buf_q;
         data_d  = data_q;
         coeff_d = coeff_q;
         if (ld_commit) begin
            if (ld_tgt_coeff) coeff_d = src;
            else              data_d  = src;
         end
         pp_d[0] = prod;
         for (int s = 1; s < MUL_STAGES; s++) pp_d[s] = pp_q[s-1];
         acc_d = acc_q;
         if (acc_en) acc_d = acc_q + ext;
         if (wr_go)  acc_d = '0;
         wr_d = wr_go ? acc_q : wr_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            buf_q   <= '0;
            data_q  <= '0;
            coeff_q <= '0;
            acc_q   <= '0;
            wr_q    <= '0;
            for (int s = 0; s < MUL_STAGES; s++) pp_q[s] <= '0;
         end else begin
            buf_q   <= buf_d;
            data_q  <= data_d;
            coeff_q <= coeff_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
            for (int s = 0; s < MUL_STAGES; s++) pp_q[s] <= pp_d[s];
         end
      end

      assign wr_data[gi*ACC_W +: ACC_W] = wr_q;
   end
endmodule

// File: tb/tb_mac_pipe.sv
// Self-checking bench for mac_pipe: directed scenarios plus randomized instruction stream,
// compared every cycle against a transaction-level model with explicit due-edge queues.
module tb_mac_pipe;
   localparam int DW = 8, AW = 20, LN = 4, MS = 2, LC = 2;
   localparam int AMASK = (1 << AW) - 1;
   localparam logic [7:0] I_NOP = 8'h01, I_LDD = 8'h02, I_LDC = 8'h04,
                          I_MAC = 8'h18, I_WR  = 8'h20;

   logic              clk = 1'b0, rst_n = 1'b0;
   logic [7:0]        inst = 8'h01;
   logic              inst_valid = 1'b0;
   logic              inst_ready;
   logic [LN*DW-1:0]  data_in = '0, coeff_in = '0;
   logic [LN*AW-1:0]  wr_data;
   logic              wr_valid, err;
   logic [15:0]       stall_cnt;

   mac_pipe #(.DATA_W(DW), .ACC_W(AW), .LANES(LN), .MUL_STAGES(MS), .LOAD_CYC(LC)) dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .data_in(data_in), .coeff_in(coeff_in), .wr_data(wr_data), .wr_valid(wr_valid),
      .err(err), .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: architectural registers plus queues of pending effects keyed by edge index.
   typedef struct packed { int due; bit coeff; logic [LN*DW-1:0] v; } ld_t;
   typedef struct packed { int due; logic [LN*32-1:0] p; } mac_t;
   ld_t  ldq[$];
   mac_t macq[$];
   int   e, ld_ready_edge, m_stall;
   int   m_data[LN], m_coeff[LN], m_acc[LN], m_wr[LN];
   bit   m_wrv, m_err;

   function automatic logic [LN*DW-1:0] fill(input int v);
      logic [LN*DW-1:0] r;
      for (int l = 0; l < LN; l++) r[l*DW +: DW] = v[DW-1:0];
      return r;
   endfunction

   function automatic logic [LN*DW-1:0] rnd_ops();
      logic [LN*DW-1:0] r;
      for (int l = 0; l < LN; l++) r[l*DW +: DW] = DW'($urandom);
      return r;
   endfunction

   function automatic bit pred_ready(input logic [7:0] i);
      if (i == I_LDD || i == I_LDC || i == I_MAC) return e >= ld_ready_edge;
      if (i == I_WR) return macq.size() == 0;
      return 1'b1;
   endfunction

   task automatic model_edge(input logic [7:0] i, input bit acc,
                             input logic [LN*DW-1:0] d, input logic [LN*DW-1:0] c);
      bit legal;
      mac_t mt;
      ld_t  lt;
      int   t;
      logic signed [DW-1:0] t8;
      legal = (i == I_NOP) || (i == I_LDD) || (i == I_LDC) || (i == I_MAC) || (i == I_WR);
      m_wrv = acc && (i == I_WR);
      m_err = acc && !legal;
      while (macq.size() > 0 && macq[0].due == e) begin
         mt = macq.pop_front();
         for (int l = 0; l < LN; l++) begin
            t = mt.p[l*32 +: 32];
            m_acc[l] = (m_acc[l] + t) & AMASK;
         end
      end
      if (acc && i == I_WR) begin
         for (int l = 0; l < LN; l++) begin
            m_wr[l]  = m_acc[l];
            m_acc[l] = 0;
         end
      end
      if (acc && i == I_MAC) begin
         mt.due = e + MS;
         for (int l = 0; l < LN; l++) mt.p[l*32 +: 32] = m_data[l] * m_coeff[l];
         macq.push_back(mt);
      end
      if (acc && (i == I_LDD || i == I_LDC)) begin
         lt.due = e + LC - 1;
         lt.coeff = (i == I_LDC);
         lt.v = lt.coeff ? c : d;
         ldq.push_back(lt);
         ld_ready_edge = e + LC;
      end
      while (ldq.size() > 0 && ldq[0].due == e) begin
         lt = ldq.pop_front();
         for (int l = 0; l < LN; l++) begin
            t8 = lt.v[l*DW +: DW];
            if (lt.coeff) m_coeff[l] = t8;
            else          m_data[l]  = t8;
         end
      end
      e++;
   endtask

   // One clock cycle: drive after the edge, check on the falling edge, advance the model on the rising edge.
   task automatic cycle(input logic [7:0] i, input bit v, input logic [LN*DW-1:0] d,
                        input logic [LN*DW-1:0] c, output bit acc);
      bit r;
      inst = i; inst_valid = v; data_in = d; coeff_in = c;
      @(negedge clk);
      r = pred_ready(i);
      check("inst_ready", inst_ready, r);
      check("wr_valid", wr_valid, m_wrv);
      check("err", err, m_err);
      check("stall_cnt", stall_cnt, m_stall);
      for (int l = 0; l < LN; l++) check("wr_data", wr_data[l*AW +: AW], m_wr[l]);
      $display("cyc %0d inst %02h valid %0b ready %0b wr_valid %0b err %0b stall %0d",
               e, i, v, inst_ready, wr_valid, err, stall_cnt);
      @(posedge clk);
      acc = v && r;
      if (v && !r && m_stall < 65535) m_stall++;
      model_edge(i, acc, d, c);
      #1;
   endtask

   task automatic issue(input logic [7:0] i, input logic [LN*DW-1:0] d, input logic [LN*DW-1:0] c);
      bit a;
      int n;
      n = 0;
      do begin
         cycle(i, 1'b1, d, c, a);
         n++;
      end while (!a && n < 40);
      check("issue_accept", a, 1'b1);
   endtask

   task automatic nops(input int n);
      bit a;
      repeat (n) cycle(I_NOP, 1'b1, '0, '0, a);
   endtask

   task automatic do_reset(input int hold);
      inst = I_NOP; inst_valid = 1'b1; rst_n = 1'b0;
      #1;
      check("rst_ready", inst_ready, 1'b0);
      check("rst_wr_valid", wr_valid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_stall", stall_cnt, 16'd0);
      for (int l = 0; l < LN; l++) check("rst_wr_data", wr_data[l*AW +: AW], 0);
      $display("reset asserted");
      repeat (hold) @(posedge clk);
      #1;
      rst_n = 1'b1; inst_valid = 1'b0;
      ldq.delete(); macq.delete();
      for (int l = 0; l < LN; l++) begin
         m_data[l] = 0; m_coeff[l] = 0; m_acc[l] = 0; m_wr[l] = 0;
      end
      m_wrv = 1'b0; m_err = 1'b0; m_stall = 0; e = 0; ld_ready_edge = 0;
   endtask

   initial begin
      int s0;
      bit a;
      logic [7:0] ri;
      do_reset(2);

      // All lanes 3*5 accumulated four times.
      issue(I_LDD, fill(3), '0);
      issue(I_LDC, '0, fill(5));
      repeat (4) issue(I_MAC, '0, '0);
      issue(I_WR, '0, '0);
      check("dir_sum60", wr_data[AW-1:0], 60);
      check("dir_sum60_l3", wr_data[3*AW +: AW], 60);
      nops(2);

      // Back-to-back loads hit the busy load port exactly once.
      s0 = m_stall;
      issue(I_LDC, '0, fill(9));
      issue(I_LDD, fill(-4), '0);
      check("dir_ld_stall", stall_cnt, s0 + 1);
      nops(1);
      issue(I_MAC, '0, '0);
      nops(3);

      // MAC right after a data load must use the new data.
      issue(I_WR, '0, '0);
      issue(I_LDC, '0, fill(2));
      nops(2);
      issue(I_LDD, fill(7), '0);
      s0 = m_stall;
      issue(I_MAC, '0, '0);
      check("dir_raw_stall", stall_cnt, s0 + 1);
      issue(I_WR, '0, '0);
      check("dir_raw14", wr_data[AW-1:0], 14);

      // WRITE right behind a MAC waits for it.
      issue(I_MAC, '0, '0);
      issue(I_WR, '0, '0);
      check("dir_wr_after_mac", wr_data[AW-1:0], 14);

      // Wrap-around of the accumulator.
      issue(I_LDD, fill(-128), '0);
      issue(I_LDC, '0, fill(-128));
      repeat (64) issue(I_MAC, '0, '0);
      issue(I_WR, '0, '0);
      check("dir_wrap0", wr_data[AW-1:0], 0);
      repeat (63) issue(I_MAC, '0, '0);
      issue(I_WR, '0, '0);
      check("dir_wrap63", wr_data[2*AW +: AW], 1032192);

      // Illegal instruction: err pulse only.
      cycle(I_LDD | I_WR, 1'b1, fill(55), fill(55), a);
      cycle(8'h00, 1'b1, fill(1), fill(1), a);
      issue(I_MAC, '0, '0);
      nops(3);

      // Reset in the middle of a MAC burst discards everything.
      repeat (3) issue(I_MAC, '0, '0);
      do_reset(1);
      nops(4);
      issue(I_WR, '0, '0);
      check("dir_rst_acc0", wr_data[AW-1:0], 0);

      // Randomized instruction mix.
      for (int n = 0; n < 800; n++) begin
         case ($urandom_range(0, 9))
            0: ri = I_NOP;
            1: ri = I_LDD;
            2: ri = I_LDC;
            3, 4, 5: ri = I_MAC;
            6: ri = I_WR;
            7: ri = 8'($urandom);
            default: ri = ($urandom_range(0, 1) == 0) ? I_LDD : I_MAC;
         endcase
         cycle(ri, $urandom_range(0, 3) != 0, rnd_ops(), rnd_ops(), a);
         if (n == 400) do_reset(2);
      end
      nops(4);
      issue(I_WR, '0, '0);
      nops(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mac_pipe.md
MAC_PIPE -- requirements
Module: mac_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed operand width per lane.
REQ-002 SHALL have parameter ACC_W, default 20: signed accumulator width per lane; ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter LANES, default 4: number of parallel MAC channels.
REQ-004 SHALL have parameter MUL_STAGES, default 2: MAC latency from acceptance to accumulator update; at least 1.
REQ-005 SHALL have parameter LOAD_CYC, default 2: cycles the shared load port is occupied per load; at least 1.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port inst, input, 8 bits: one-hot instruction word. Bit 0 = NOP, 1 = LD_DATA, 2 = LD_COEFF, 3 = ADD, 4 = MULT, 5 = WRITE; bits 6-7 reserved.
REQ-009 SHALL have port inst_valid, input, 1 bit: inst is present.
REQ-010 SHALL have port inst_ready, output, 1 bit: inst is accepted this edge; combinational from hazard state and inst.
REQ-011 SHALL have port data_in, input, LANES*DATA_W bits: lane operands for LD_DATA; lane 0 in the LSBs.
REQ-012 SHALL have port coeff_in, input, LANES*DATA_W bits: lane operands for LD_COEFF.
REQ-013 SHALL have port wr_data, output, LANES*ACC_W bits: accumulator snapshot.
REQ-014 SHALL have port wr_valid, output, 1 bit: one-cycle strobe qualifying wr_data.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse on an accepted illegal instruction.
REQ-016 SHALL have port stall_cnt, output, 16 bits: saturating count of cycles with inst_valid=1 and inst_ready=0.

Function
REQ-017 SHALL accept an instruction at a rising edge when inst_valid=1 and inst_ready=1.
REQ-018 SHALL decode the legal classes as NOP (bit 0 only), LD_DATA, LD_COEFF, MAC (bits 3 and 4 together, nothing else) and WRITE; every other pattern, including zero, SHALL be illegal.
REQ-019 SHALL, on accepting an illegal instruction, take no action other than pulsing err high for the following cycle; illegal instructions SHALL never stall.
REQ-020 SHALL, on accepting a load at edge T, sample data_in/coeff_in at T, write the data/coeff register at edge T+LOAD_CYC-1, and hold the load port busy until then.
REQ-021 SHALL hold inst_ready=0 for a load while the load port is busy (structural hazard).
REQ-022 SHALL hold inst_ready=0 for a MAC while any load is in flight (RAW hazard), so that a MAC always uses the newest operands.
REQ-023 SHALL, on accepting a MAC at edge T, sample the operands at T, form the full-precision signed product 2*DATA_W per lane, sign-extend it to ACC_W, and add it to the accumulator at edge T+MUL_STAGES.
REQ-024 SHALL wrap accumulation modulo 2^ACC_W (no saturation).
REQ-025 SHALL sustain one MAC per cycle back-to-back.
REQ-026 SHALL hold inst_ready=0 for WRITE while any accepted MAC has not yet updated the accumulator.
REQ-027 SHALL, on accepting WRITE at edge T, set wr_data to the accumulator value at T, drive wr_valid=1 for exactly the cycle after T, and clear all accumulators at T.
REQ-028 SHALL allow a MAC accepted at T+1 after a WRITE at T to accumulate from 0.
REQ-029 SHALL hold wr_data until the next WRITE.
REQ-030 SHALL accept NOP whenever inst_valid=1.
REQ-031 SHALL saturate stall_cnt at 16'hFFFF.

Reset
REQ-032 SHALL, while rst_n=0, immediately clear the data, coeff and accumulator registers, the MAC pipeline, the load counter, wr_data, wr_valid, err and stall_cnt, and force inst_ready=0.
REQ-033 SHALL discard in-flight loads and MACs on reset mid-operation; no wr_valid or accumulator update from them SHALL follow.
REQ-034 SHALL accept instructions from the first rising edge after rst_n rises.

Verification
REQ-035 SHALL be checked with this directed scenario (default params): LD_DATA with all lanes 3, LD_COEFF with all lanes 5, 4x MAC, WRITE -> wr_data is 60 in every lane; wr_valid high for exactly 1 cycle.
REQ-036 SHALL be checked with this directed scenario: LD_COEFF then LD_DATA on consecutive cycles -> inst_ready low for 1 cycle; stall_cnt=1; both registers end up loaded correctly.
REQ-037 SHALL be checked with this directed scenario: MAC presented the cycle after LD_DATA (data 7, coeff 2) -> 1 stall cycle; the accumulator gains 14, not the old-data product.
REQ-038 SHALL be checked with this directed scenario: WRITE presented the cycle after a MAC -> stalled until the accumulator update; wr_data includes that MAC.
REQ-039 SHALL be checked with this directed scenario: data=-128, coeff=-128, 64 MACs, WRITE -> wr_data=0 in every lane (wraps at 2^20); 63 MACs -> 1032192.
REQ-040 SHALL be checked with this directed scenario: inst=LD_DATA|WRITE -> err pulses for 1 cycle with no state change; rst_n low during a MAC burst -> accumulators 0; no wr_valid.
